bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each digit stays enabled; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 = leading-zero blanking on, 0 = all three digits always lit.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port bin, input, 9: unsigned binary value from the upstream 0..211 counter; full range 0..511 accepted.
REQ-006 SHALL have port bin_valid, input, 1: conversion request, sampled on clk.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port bcd, output, 12: latched result, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 SHALL have port bcd_valid, output, 1: one-cycle pulse when bcd updates.
REQ-010 SHALL have port seg, output, 7: active-high segments, bit order [6:0] = g f e d c b a.
REQ-011 SHALL have port an, output, 3: one-hot active-high digit enable; [0] ones, [1] tens, [2] hundreds.

Function
REQ-012 SHALL implement the converter FSM with states IDLE, SHIFT and DONE; busy = (state != IDLE).
REQ-013 IDLE: bin_valid=1 at an edge SHALL capture bin into shift register bits [8:0], clear the 12-bit BCD field, set the shift count to 0 and go to SHIFT; bin_valid=0 stays in IDLE.
REQ-014 SHIFT, each edge: SHALL add 3 to every BCD nibble >= 5, then shift the 21-bit {bcd, bin} register left by 1 and increment the count.
REQ-015 SHIFT SHALL go to DONE on the edge that performs the 9th shift.
REQ-016 DONE, one edge: SHALL load bcd from the BCD field, drive bcd_valid=1 for exactly the following cycle and go to IDLE.
REQ-017 Capture at edge N SHALL give new bcd and bcd_valid=1 after edge N+10, with busy low in that same cycle.
REQ-018 bin_valid while busy=1 SHALL be ignored: no queueing and no effect on the running conversion.
REQ-019 bin_valid=1 in the bcd_valid cycle SHALL be accepted, giving back-to-back conversions every 11 cycles.
REQ-020 bcd SHALL hold its value between conversions; the scanner SHALL always display the latched bcd, never intermediate values.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index advances ones -> tens -> hundreds -> ones.
REQ-022 an SHALL be the one-hot of the digit index; seg SHALL be the 7-segment decode of the selected nibble; both are combinational from registers.
REQ-023 Decode SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; nibbles 10..15 give 0000000.
REQ-024 With BLANK_LZ=1: hundreds SHALL be blanked (seg=0) when its nibble is 0; tens SHALL be blanked when hundreds and tens are both 0; ones SHALL never be blanked; an still asserts for a blanked digit.
REQ-025 Converter and scanner SHALL run independently; a conversion SHALL NOT stall or reset the scan.

Reset
REQ-026 reset=0 at an edge SHALL set state=IDLE, shift register=0, count=0, bcd=0x000, bcd_valid=0, scan counter=0 and digit index=ones, overriding all other inputs.
REQ-027 Immediately after reset: busy=0, an=001, seg=0111111.
REQ-028 reset mid-conversion SHALL abort the conversion, leave bcd=0x000 and produce no bcd_valid pulse.

Structure
REQ-029 Shared package count_disp_pkg SHALL hold the FSM state enum, the digit-index constants and the segment pattern constants from REQ-023.
REQ-030 Sub-module seg7_decode SHALL be the combinational nibble-to-segment decoder; bcd_scan_display instantiates it once.

Verification
REQ-031 Reset: hold reset=0 for 2 cycles -> bcd=000, busy=0, bcd_valid=0, an=001, seg=0111111.
REQ-032 Conversion: bin=211 with a one-cycle bin_valid at edge N -> busy high for cycles N+1..N+10, bcd=0x211 and bcd_valid=1 only in the cycle after edge N+10; bin=511 -> 0x511; bin=0 -> 0x000.
REQ-033 Blanking and scan (SCAN_DIV=4, BLANK_LZ=1): bcd=0x007 -> an steps 001 -> 010 -> 100 every 4 cycles, seg = 0000111, then 0000000, then 0000000.
REQ-034 Ignore while busy: bin=100 then bin=200 with bin_valid 3 cycles later -> single result 0x100, one bcd_valid pulse.
REQ-035 Reset mid-conversion: bin=150, reset=0 at capture edge +5 -> no bcd_valid pulse, bcd=0x000, busy=0; a following request with bin=42 -> 0x042.
REQ-036 Back-to-back: bin_valid held high, bin stepping 209, 210, 211, 0 -> results 0x209, 0x210, 0x211, 0x000, 11 cycles apart.

Source files
------------

// File: rtl/count_disp_pkg.sv
// Shared definitions for the BCD converter and multiplexed display scanner:
// converter states, digit-index codes and 7-segment patterns (g f e d c b a).
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int BIN_W = 9;
  localparam int BCD_W = 12;
  localparam int SR_W  = BCD_W + BIN_W;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUNDS = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: any nibble >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment decoder; codes 10..15 are dark.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// 9-bit binary to 3-digit BCD converter (shift-add-3, 11 cycles per result)
// feeding an independent time-multiplexed 3-digit 7-segment scanner.
module bcd_scan_display
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  bin,
  input  logic        bin_valid,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  conv_state_e     state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic [15:0]     scan_q, scan_d;
  logic [1:0]      dig_q, dig_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      scan_q      <= '0;
      dig_q       <= DIG_ONES;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      scan_q      <= scan_d;
      dig_q       <= dig_d;
    end
  end

  // Converter: requests arriving outside IDLE are dropped, not queued.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bin_valid) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {dabble_adjust(sr_q[SR_W-1:BIN_W]), sr_q[BIN_W-1:0]} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d       = sr_q[SR_W-1:BIN_W];
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + 16'd1;
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_HUNDS) ? DIG_ONES : dig_q + 2'd1;
    end
  end

  logic [3:0] nib;
  logic [6:0] dec_seg;
  logic       blank;

  // Only the latched bcd_q is ever shown, so the display never sees partial sums.
  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    case (dig_q)
      DIG_TENS: begin
        nib   = bcd_q[7:4];
        blank = (BLANK_LZ != 0) && (bcd_q[11:4] == 8'd0);
      end
      DIG_HUNDS: begin
        nib   = bcd_q[11:8];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0);
      end
      default: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble_i (nib),
    .seg_o    (dec_seg)
  );

  assign busy      = (state_q != IDLE);
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign an        = 3'b001 << dig_q;
  assign seg       = blank ? SEG_BLANK : dec_seg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (SCAN_DIV=4, BLANK_LZ=1) against a
// decimal-arithmetic reference model of the converter and display.
module tb_bcd_scan_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  bin = '0;
  logic        bin_valid = 1'b0;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  an;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_cyc = 0;
  logic [11:0] disp_bcd = '0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  bcd_scan_display #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin       (bin),
    .bin_valid (bin_valid),
    .busy      (busy),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Expected {an, seg} from the latched value and cycles elapsed since reset.
  function automatic logic [9:0] model_disp(input logic [11:0] b, input int k);
    int idx, h, t, o, n;
    logic [6:0] s;
    idx = (k / SD) % 3;
    h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
    n = (idx == 0) ? o : (idx == 1) ? t : h;
    s = (n < 10) ? seg_tab[n] : 7'b0000000;
    if (idx == 2 && h == 0) s = 7'b0000000;
    if (idx == 1 && h == 0 && t == 0) s = 7'b0000000;
    return {3'(1 << idx), s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    rst_cyc = cyc;
    disp_bcd = '0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bin = 9'(211);
    bin_valid = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    rst_cyc = cyc;
    disp_bcd = '0;
    tests++;
    if (bcd !== 12'h000) begin fails++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++;
    if (bcd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
    tests++;
    if (an !== 3'b001) begin fails++; $display("FAIL reset_an got=%b exp=001", an); end
    tests++;
    if (seg !== 7'b0111111) begin fails++; $display("FAIL reset_seg got=%b exp=0111111", seg); end
    bin_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic convert(input int v, input string nm);
    logic [11:0] exp_b;
    exp_b = to_bcd(v);
    bin = 9'(v);
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    bin = 9'($urandom_range(0, 511));
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (busy !== 1'b1 || bcd_valid !== 1'b0 || bcd !== disp_bcd) begin
        fails++;
        $display("FAIL %s_busy c%0d got busy=%b vld=%b bcd=%h exp busy=1 vld=0 bcd=%h",
                 nm, i, busy, bcd_valid, bcd, disp_bcd);
      end
      tests++;
      if ({an, seg} !== model_disp(disp_bcd, cyc - rst_cyc)) begin
        fails++;
        $display("FAIL %s_disp got=%b exp=%b", nm, {an, seg}, model_disp(disp_bcd, cyc - rst_cyc));
      end
      tick();
    end
    disp_bcd = exp_b;
    tests++;
    if (busy !== 1'b0 || bcd_valid !== 1'b1 || bcd !== exp_b) begin
      fails++;
      $display("FAIL %s_result got busy=%b vld=%b bcd=%h exp busy=0 vld=1 bcd=%h",
               nm, busy, bcd_valid, bcd, exp_b);
    end
    tests++;
    if ({an, seg} !== model_disp(disp_bcd, cyc - rst_cyc)) begin
      fails++;
      $display("FAIL %s_disp_new got=%b exp=%b", nm, {an, seg}, model_disp(disp_bcd, cyc - rst_cyc));
    end
    tick();
    tests++;
    if (bcd_valid !== 1'b0 || bcd !== exp_b) begin
      fails++;
      $display("FAIL %s_hold got vld=%b bcd=%h exp vld=0 bcd=%h", nm, bcd_valid, bcd, exp_b);
    end
  endtask

  task automatic test_conversion();
    convert(211, "conv211");
    convert(511, "conv511");
    convert(0, "conv0");
  endtask

  task automatic test_scan_blank();
    do_reset();
    convert(7, "scan7");
    for (int i = 0; i < 3 * SD * 2; i++) begin
      tests++;
      if ({an, seg} !== model_disp(disp_bcd, cyc - rst_cyc)) begin
        fails++;
        $display("FAIL scan_disp got=%b exp=%b", {an, seg}, model_disp(disp_bcd, cyc - rst_cyc));
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    pulses = 0;
    bin = 9'(100);
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    tick();
    tick();
    bin = 9'(200);
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (bcd_valid === 1'b1) pulses++;
      tick();
    end
    disp_bcd = 12'h100;
    tests++;
    if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    tests++;
    if (bcd !== 12'h100) begin fails++; $display("FAIL ignore_bcd got=%h exp=100", bcd); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ignore_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    bin = 9'(150);
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    rst_cyc = cyc;
    disp_bcd = '0;
    reset = 1'b1;
    tests++;
    if (busy !== 1'b0 || bcd !== 12'h000) begin
      fails++;
      $display("FAIL midrst_state got busy=%b bcd=%h exp busy=0 bcd=000", busy, bcd);
    end
    for (int i = 0; i < 12; i++) begin
      if (bcd_valid === 1'b1) pulses++;
      tick();
    end
    tests++;
    if (pulses !== 0 || bcd !== 12'h000) begin
      fails++;
      $display("FAIL midrst_nopulse got pulses=%0d bcd=%h exp pulses=0 bcd=000", pulses, bcd);
    end
    convert(42, "midrst42");
  endtask

  task automatic test_back_to_back();
    int vals [4] = '{209, 210, 211, 0};
    int start, prev;
    prev = -1;
    bin = 9'(vals[0]);
    bin_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bin = 9'(vals[j]);
      tick();
      start = cyc;
      bin = 9'(vals[(j + 1) % 4]);
      for (int i = 0; i < 10; i++) tick();
      if (j == 3) bin_valid = 1'b0;
      disp_bcd = to_bcd(vals[j]);
      tests++;
      if (bcd_valid !== 1'b1 || bcd !== to_bcd(vals[j])) begin
        fails++;
        $display("FAIL b2b_%0d got vld=%b bcd=%h exp vld=1 bcd=%h", j, bcd_valid, bcd, to_bcd(vals[j]));
      end
      if (prev >= 0) begin
        tests++;
        if (start - prev !== 11) begin
          fails++;
          $display("FAIL b2b_spacing got=%0d exp=11", start - prev);
        end
      end
      prev = start;
    end
    tick();
    tests++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_stop got busy=%b vld=%b exp busy=0 vld=0", busy, bcd_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      convert($urandom_range(0, 511), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_scan_blank();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
